// File: rtl/pwm_core_pkg.sv
// rtl/pwm_core_pkg.sv - register map constants and bus helpers for pwm_core
//
// Purpose: word addresses of the PWM register map, CTRL bit indices and the
//          byte-strobe merge used by every writable register.
// Ports:   none (package).
package pwm_core_pkg;

  localparam logic [31:0] REG_CTRL   = 32'd0;
  localparam logic [31:0] REG_PERIOD = 32'd1;
  localparam logic [31:0] REG_DUTY   = 32'd2;
  localparam logic [31:0] REG_COUNT  = 32'd3;
  localparam logic [31:0] REG_STATUS = 32'd4;

  localparam int CTRL_EN  = 0;
  localparam int CTRL_POL = 1;

  // Merge a 32-bit write into the current register image, byte by byte.
  function automatic logic [31:0] apply_wstrb(input logic [31:0] cur,
                                              input logic [31:0] data,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = cur;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = data[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/pwm_counter.sv
// rtl/pwm_counter.sv - PWM counter with double-buffered period/duty and compare
//
// Purpose: free-running period counter; active period/duty are reloaded from
//          the programmed values only at a period boundary (or while idle),
//          so mid-period writes never glitch the waveform.
// Ports:
//   clk      in   system clock
//   rst      in   synchronous active-high reset
//   en       in   counter enable (CTRL.EN)
//   pol      in   output inversion (CTRL.POL)
//   period   in   programmed PERIOD (N gives N+1 cycles)
//   duty     in   programmed DUTY (high cycles before inversion)
//   count    out  current counter value
//   boundary out  one-cycle pulse on the last cycle of a period while enabled
//   pwm      out  registered PWM waveform
import pwm_core_pkg::*;

module pwm_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             pol,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] duty,
  output logic [CNT_W-1:0] count,
  output logic             boundary,
  output logic             pwm
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] per_act;
  logic [CNT_W-1:0] duty_act;
  logic             pwm_q;

  assign boundary = en && (cnt_q == per_act);
  assign count    = cnt_q;
  assign pwm      = pwm_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      per_act  <= '0;
      duty_act <= '0;
      pwm_q    <= 1'b0;
    end else begin
      // Output lags the counter by one cycle; idle output sits at POL.
      pwm_q <= (en && (cnt_q < duty_act)) ^ pol;
      // While idle the shadows track the programmed values so that enabling
      // starts straight away with fresh settings at cnt=0.
      if (!en || boundary) begin
        per_act  <= period;
        duty_act <= duty;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pwm_core.sv
// rtl/pwm_core.sv - register-programmable PWM generator on the native valid/ready bus
//
// Purpose: bus decode and programmed registers (CTRL, PERIOD, DUTY, STATUS);
//          waveform generation lives in pwm_counter.
// Optional feature macro: PWM_IRQ_EN (period-end interrupt with W1C STATUS.PEND).
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   valid      in   bus request
//   address    in   word address
//   wdata      in   write data
//   wstrb      in   byte write strobes, all-zero means read
//   rdata      out  read data, valid with ready
//   ready      out  one-cycle acknowledge, the cycle after valid
//   pwm_output out  PWM waveform
//   irq        out  period-end interrupt (0 when PWM_IRQ_EN is undefined)
import pwm_core_pkg::*;

module pwm_core #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  output logic [DATA_W-1:0]   rdata,
  output logic                ready,
  output logic                pwm_output,
  output logic                irq
);

  logic [1:0]        ctrl_q;
  logic [CNT_W-1:0]  period_q;
  logic [CNT_W-1:0]  duty_q;
  logic [CNT_W-1:0]  count;
  logic              boundary;
  logic              wr;
  logic [31:0]       addr_ext;
  logic [DATA_W-1:0] ctrl_ext, per_ext, duty_ext, cnt_ext, status_ext, rd_val;
  logic [DATA_W-1:0] ctrl_new, per_new, duty_new;
  logic              pend;

  assign wr       = valid && (wstrb != '0);
  assign addr_ext = 32'(address);

`ifdef PWM_IRQ_EN
  logic pend_q;

  // A boundary in the same cycle as a W1C write keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= 1'b0;
    end else if (boundary) begin
      pend_q <= 1'b1;
    end else if (wr && addr_ext == REG_STATUS && wstrb[0] && wdata[0]) begin
      pend_q <= 1'b0;
    end
  end

  assign pend = pend_q;
  assign irq  = pend_q;
`else
  assign pend = 1'b0;
  assign irq  = 1'b0;
`endif

  // Registers are zero-extended to the bus width so that strobes and
  // read-back treat every register identically.
  always_comb begin
    ctrl_ext             = '0;
    ctrl_ext[1:0]        = ctrl_q;
    per_ext              = '0;
    per_ext[CNT_W-1:0]   = period_q;
    duty_ext             = '0;
    duty_ext[CNT_W-1:0]  = duty_q;
    cnt_ext              = '0;
    cnt_ext[CNT_W-1:0]   = count;
    status_ext           = '0;
    status_ext[0]        = pend;
    ctrl_new             = apply_wstrb(ctrl_ext, wdata, wstrb);
    per_new              = apply_wstrb(per_ext, wdata, wstrb);
    duty_new             = apply_wstrb(duty_ext, wdata, wstrb);
    case (addr_ext)
      REG_CTRL:   rd_val = ctrl_ext;
      REG_PERIOD: rd_val = per_ext;
      REG_DUTY:   rd_val = duty_ext;
      REG_COUNT:  rd_val = cnt_ext;
      REG_STATUS: rd_val = status_ext;
      default:    rd_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ready    <= 1'b0;
      rdata    <= '0;
      ctrl_q   <= '0;
      period_q <= '0;
      duty_q   <= '0;
    end else begin
      ready <= valid;
      rdata <= (valid && !wr) ? rd_val : '0;
      if (wr) begin
        case (addr_ext)
          REG_CTRL:   ctrl_q   <= ctrl_new[1:0];
          REG_PERIOD: period_q <= per_new[CNT_W-1:0];
          REG_DUTY:   duty_q   <= duty_new[CNT_W-1:0];
          default:    ;
        endcase
      end
    end
  end

  pwm_counter #(.CNT_W(CNT_W)) u_counter (
    .clk      (clk),
    .rst      (rst),
    .en       (ctrl_q[CTRL_EN]),
    .pol      (ctrl_q[CTRL_POL]),
    .period   (period_q),
    .duty     (duty_q),
    .count    (count),
    .boundary (boundary),
    .pwm      (pwm_output)
  );

  // Upper merged bits and (without the interrupt) the boundary pulse are
  // intentionally dropped.
  logic unused_sink;
  assign unused_sink = ^{ctrl_new, per_new, duty_new, boundary};

endmodule

// File: tb/tb_pwm_core.sv
// tb/tb_pwm_core.sv - directed table-driven bench for pwm_core
module tb_pwm_core;

  localparam logic [2:0] A_CTRL   = 3'd0;
  localparam logic [2:0] A_PERIOD = 3'd1;
  localparam logic [2:0] A_DUTY   = 3'd2;
  localparam logic [2:0] A_COUNT  = 3'd3;
  localparam logic [2:0] A_STATUS = 3'd4;
  localparam logic [3:0] ALL      = 4'hF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic [2:0]  address = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic [31:0] rdata;
  logic        ready;
  logic        pwm_output;
  logic        irq;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string       name;
    logic [15:0] period;
    logic [15:0] duty;
    logic        pol;
  } vec_t;

  vec_t vecs[9];

  pwm_core #(.DATA_W(32), .ADDR_W(3), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .valid      (valid),
    .address    (address),
    .wdata      (wdata),
    .wstrb      (wstrb),
    .rdata      (rdata),
    .ready      (ready),
    .pwm_output (pwm_output),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the next negedge with the ack visible.
  task automatic bus_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] s);
    valid = 1'b1; address = a; wdata = d; wstrb = s;
    @(negedge clk);
    valid = 1'b0; wstrb = '0;
    check("write_ready", 32'(ready), 32'd1);
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    valid = 1'b1; address = a; wstrb = '0;
    @(negedge clk);
    valid = 1'b0;
    check("read_ready", 32'(ready), 32'd1);
    d = rdata;
  endtask

  task automatic start(input logic [15:0] p, input logic [15:0] dty, input logic pol);
    bus_write(A_CTRL, 32'd0, ALL);
    bus_write(A_PERIOD, 32'(p), ALL);
    bus_write(A_DUTY, 32'(dty), ALL);
    bus_write(A_CTRL, {30'd0, pol, 1'b1}, ALL);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    int          p, dt, e;
    bit          seen;

    vecs[0] = '{"p9_d3",      16'd9, 16'd3,  1'b0};
    vecs[1] = '{"p9_d0",      16'd9, 16'd0,  1'b0};
    vecs[2] = '{"p9_d20",     16'd9, 16'd20, 1'b0};
    vecs[3] = '{"p9_d0_pol",  16'd9, 16'd0,  1'b1};
    vecs[4] = '{"p9_d20_pol", 16'd9, 16'd20, 1'b1};
    vecs[5] = '{"p9_d3_pol",  16'd9, 16'd3,  1'b1};
    vecs[6] = '{"p0_d1",      16'd0, 16'd1,  1'b0};
    vecs[7] = '{"p4_d5",      16'd4, 16'd5,  1'b0};
    vecs[8] = '{"p4_d4",      16'd4, 16'd4,  1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_pwm", 32'(pwm_output), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    bus_read(A_PERIOD, d);  check("rst_period", d, 32'd0);
    bus_read(A_COUNT, d);   check("rst_count", d, 32'd0);

    // Table-driven waveform vectors: sample i sees counter value i mod (P+1)
    foreach (vecs[k]) begin
      start(vecs[k].period, vecs[k].duty, vecs[k].pol);
      p  = int'(vecs[k].period);
      dt = int'(vecs[k].duty);
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        e = (((i % (p + 1)) < dt) ? 1 : 0) ^ int'(vecs[k].pol);
        check(vecs[k].name, 32'(pwm_output), 32'(e));
      end
    end

    // Mid-period DUTY write takes effect only from the next period
    start(16'd9, 16'd3, 1'b0);
    for (int i = 0; i < 30; i++) begin
      if (i == 4) bus_write(A_DUTY, 32'd7, ALL);
      else        @(negedge clk);
      e = ((i % 10) < ((i < 10) ? 3 : 7)) ? 1 : 0;
      check("mid_duty", 32'(pwm_output), 32'(e));
    end

    // EN 1->0: counter and output idle on the following cycle
    bus_write(A_CTRL, 32'd0, ALL);
    @(negedge clk);
    check("dis_pwm", 32'(pwm_output), 32'd0);
    bus_read(A_COUNT, d); check("dis_count", d, 32'd0);

    // EN=0 with POL=1 gives constant high
    bus_write(A_CTRL, 32'd2, ALL);
    repeat (3) @(negedge clk);
    check("idle_pol", 32'(pwm_output), 32'd1);

    // PERIOD=0: COUNT stays 0; unmapped address reads 0 with a single ready
    start(16'd0, 16'd1, 1'b0);
    repeat (3) @(negedge clk);
    check("p0_pwm", 32'(pwm_output), 32'd1);
    bus_read(A_COUNT, d); check("p0_count", d, 32'd0);
    bus_write(3'd5, 32'hFFFF_FFFF, ALL);
    bus_read(3'd7, d);    check("addr7_rdata", d, 32'd0);
    @(negedge clk);
    check("ready_one_cycle", 32'(ready), 32'd0);
    bus_read(A_CTRL, d);  check("ctrl_readback", d, 32'd1);

    // Byte strobes and PERIOD upper-bit masking
    bus_write(A_PERIOD, 32'h0000_1234, ALL);
    bus_write(A_PERIOD, 32'h0000_FFFF, 4'b0001);
    bus_read(A_PERIOD, d); check("wstrb_lane0", d, 32'h0000_12FF);
    bus_write(A_DUTY, 32'hABCD_5678, ALL);
    bus_read(A_DUTY, d);   check("duty_mask", d, 32'h0000_5678);

`ifdef PWM_IRQ_EN
    start(16'd9, 16'd3, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      seen = irq;
    end
    check("irq_rise", 32'(seen), 32'd1);
    bus_read(A_STATUS, d); check("status_pend", d, 32'd1);
    bus_write(A_STATUS, 32'd1, ALL);
    check("irq_w1c", 32'(irq), 32'd0);
    bus_read(A_STATUS, d); check("status_clr", d, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      seen = irq;
    end
    check("irq_rise2", 32'(seen), 32'd1);
`else
    start(16'd9, 16'd3, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      seen = seen | irq;
    end
    check("irq_tied0", 32'(seen), 32'd0);
    bus_read(A_STATUS, d); check("status_zero", d, 32'd0);
`endif

    // Reset mid-period, with a read in flight, returns everything to power-up
    repeat (2) @(negedge clk);
    valid = 1'b1; address = A_PERIOD; wstrb = '0;
    rst = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    check("mrst_ready", 32'(ready), 32'd0);
    check("mrst_rdata", rdata, 32'd0);
    check("mrst_pwm", 32'(pwm_output), 32'd0);
    check("mrst_irq", 32'(irq), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    bus_read(A_CTRL, d);   check("mrst_ctrl", d, 32'd0);
    bus_read(A_PERIOD, d); check("mrst_period", d, 32'd0);
    repeat (3) @(negedge clk);
    check("mrst_pwm_idle", 32'(pwm_output), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
